sram_bank_responder: RTL and testbench

Memory-side responder for the byte-lane SRAM bus driven by the core's memory interface. It accepts a word address and per-lane read/write strobes, performs the access on a 4-lane byte-wide array after a programmable number of wait states, and returns a one-cycle ready pulse with registered read data. It sits between the memory interface and the top-level pad/tristate logic, which uses the per-lane output enables to drive the shared bidirectional data bus.

---
 rtl/sram_bank_responder_pkg.sv | 35 +++
 rtl/sram_bank_responder_if.sv | 36 +++
 rtl/sram_bank_responder_lane.sv | 46 ++++
 rtl/sram_bank_responder.sv | 161 ++++++++++++++++
 tb/tb_sram_bank_responder.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bank_responder_pkg.sv
// -----------------------------------------------------------------------------
// sram_bank_responder_pkg
// Shared definitions for the byte-lane SRAM responder: address width, lane
// geometry, FSM state encoding and the error classification codes.
// No ports (package).
// -----------------------------------------------------------------------------
package sram_bank_responder_pkg;

    localparam int XLEN   = 32;
    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_COLLIDE = 2'd1,
        ERR_RANGE   = 2'd2
    } err_e;

    // A read and a write in the same request is refused outright; that takes
    // precedence over the range check because nothing is accessed at all.
    function automatic err_e classify(input logic [LANES-1:0] rd,
                                      input logic [LANES-1:0] wr,
                                      input logic             oor);
        if ((|rd) && (|wr)) return ERR_COLLIDE;
        if (oor)            return ERR_RANGE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/sram_bank_responder_if.sv
// -----------------------------------------------------------------------------
// sram_bank_responder_if
// Byte-lane SRAM bus between the core memory interface (master) and the
// bank responder (slave).
//   sram_addr      word address
//   sram_read      per-lane read strobes
//   sram_write     per-lane write strobes
//   sram_wdata     lane-indexed write bytes
//   sram_rdata     lane-indexed registered read bytes
//   sram_rdata_oe  per-lane drive enable for the pad tristates
//   sram_ready     one-cycle completion pulse
//   sram_err       error qualifier, meaningful only with sram_ready
// -----------------------------------------------------------------------------
interface sram_bank_responder_if;
    import sram_bank_responder_pkg::*;

    logic [XLEN-1:0]               sram_addr;
    logic [LANES-1:0]              sram_read;
    logic [LANES-1:0]              sram_write;
    logic [LANES-1:0][LANE_W-1:0]  sram_wdata;
    logic [LANES-1:0][LANE_W-1:0]  sram_rdata;
    logic [LANES-1:0]              sram_rdata_oe;
    logic                          sram_ready;
    logic                          sram_err;

    modport master (
        output sram_addr, sram_read, sram_write, sram_wdata,
        input  sram_rdata, sram_rdata_oe, sram_ready, sram_err
    );

    modport slave (
        input  sram_addr, sram_read, sram_write, sram_wdata,
        output sram_rdata, sram_rdata_oe, sram_ready, sram_err
    );

endinterface

// File: rtl/sram_bank_responder_lane.sv
// -----------------------------------------------------------------------------
// sram_byte_lane
// One byte-wide storage array plus its read-data register.
//   memclk      clock
//   rstn        synchronous active-low reset (read register only)
//   addr_i      array index
//   we_i        commit wdata_i at addr_i
//   re_i        update the read register
//   rd_zero_i   with re_i: load 0x00 instead of the array word
//   wdata_i     write byte
//   rdata_o     registered read byte, held until the next read of this lane
// -----------------------------------------------------------------------------
module sram_byte_lane #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  memclk,
    input  logic                  rstn,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic                  rd_zero_i,
    input  logic [7:0]            wdata_i,
    output logic [7:0]            rdata_o
);

    logic [7:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [7:0] rdata_q;

    // Array contents deliberately have no reset.
    always_ff @(posedge memclk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge memclk) begin
        if (!rstn) begin
            rdata_q <= 8'h00;
        end else if (re_i) begin
            rdata_q <= rd_zero_i ? 8'h00 : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_bank_responder.sv
// -----------------------------------------------------------------------------
// sram_bank_responder
// Memory-side responder for the byte-lane SRAM bus. Latches a request, waits
// WAIT_STATES cycles, performs the per-lane access on four byte lanes and
// returns a one-cycle ready pulse with error qualifier and lane output enables.
//   memclk   clock
//   rstn     synchronous active-low reset
//   mem_if   sram_bank_responder_if.slave bus (see interface header)
// -----------------------------------------------------------------------------
module sram_bank_responder
    import sram_bank_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                         memclk,
    input  logic                         rstn,
    sram_bank_responder_if.slave         mem_if
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e                       state_q;
    logic [3:0]                   cnt_q;
    logic [XLEN-1:0]              addr_q;
    logic [LANES-1:0]             rd_q;
    logic [LANES-1:0]             wr_q;
    logic [LANES-1:0][LANE_W-1:0] wdata_q;
    logic                         ready_q;
    err_e                         err_q;
    logic [LANES-1:0]             oe_q;

    logic                         req_in;
    logic                         acc_fire;
    logic [XLEN-1:0]              acc_addr;
    logic [LANES-1:0]             acc_rd;
    logic [LANES-1:0]             acc_wr;
    logic [LANES-1:0][LANE_W-1:0] acc_wdata;
    logic                         acc_oor;
    err_e                         err_d;
    logic [LANES-1:0]             oe_d;
    logic [LANES-1:0]             lane_we;
    logic [LANES-1:0]             lane_re;
    logic [LANES-1:0][LANE_W-1:0] rdata_w;

    assign req_in = (|mem_if.sram_read) || (|mem_if.sram_write);

    // With zero wait states the access happens on the same edge that samples
    // the request, so the lanes must see the live bus; otherwise they see the
    // copy latched in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_addr  = mem_if.sram_addr;
            acc_rd    = mem_if.sram_read;
            acc_wr    = mem_if.sram_write;
            acc_wdata = mem_if.sram_wdata;
        end else begin
            acc_addr  = addr_q;
            acc_rd    = rd_q;
            acc_wr    = wr_q;
            acc_wdata = wdata_q;
        end
    end

    // The access edge is the one that moves the FSM into DONE. Reset gates it
    // so an abort on that same edge commits nothing.
    assign acc_fire = rstn &&
                      (((state_q == ST_IDLE) && req_in && (WS == 4'd0)) ||
                       ((state_q == ST_WAIT) && (cnt_q == 4'd1)));

    assign acc_oor = |(acc_addr >> DEPTH_LOG2);
    assign err_d   = classify(acc_rd, acc_wr, acc_oor);
    assign oe_d    = (err_d == ERR_COLLIDE) ? '0 : acc_rd;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_we[i] = acc_fire && (err_d == ERR_NONE) && acc_wr[i];
            lane_re[i] = acc_fire && (err_d != ERR_COLLIDE) && acc_rd[i];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sram_byte_lane #(
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_lane (
            .memclk    (memclk),
            .rstn      (rstn),
            .addr_i    (acc_addr[DEPTH_LOG2-1:0]),
            .we_i      (lane_we[g]),
            .re_i      (lane_re[g]),
            .rd_zero_i (acc_oor),
            .wdata_i   (acc_wdata[g]),
            .rdata_o   (rdata_w[g])
        );
    end

    // Request payload; only meaningful while strobes are latched, so no reset.
    always_ff @(posedge memclk) begin
        if ((state_q == ST_IDLE) && req_in) begin
            addr_q  <= mem_if.sram_addr;
            wdata_q <= mem_if.sram_wdata;
        end
    end

    always_ff @(posedge memclk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= '0;
            wr_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= ERR_NONE;
            oe_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_in) begin
                        rd_q  <= mem_if.sram_read;
                        wr_q  <= mem_if.sram_write;
                        cnt_q <= WS;
                        if (WS == 4'd0) begin
                            state_q <= ST_DONE;
                            ready_q <= 1'b1;
                            err_q   <= err_d;
                            oe_q    <= oe_d;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_DONE;
                        ready_q <= 1'b1;
                        err_q   <= err_d;
                        oe_q    <= oe_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= ERR_NONE;
                    oe_q    <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= ERR_NONE;
                    oe_q    <= '0;
                end
            endcase
        end
    end

    assign mem_if.sram_rdata    = rdata_w;
    assign mem_if.sram_rdata_oe = oe_q;
    assign mem_if.sram_ready    = ready_q;
    assign mem_if.sram_err      = (err_q != ERR_NONE);

endmodule

// File: tb/tb_sram_bank_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_bank_responder
// Two responders side by side (WAIT_STATES=0 and WAIT_STATES=2), each checked
// against a behavioural model of memory contents and read registers.
// -----------------------------------------------------------------------------
module tb_sram_bank_responder;

    logic memclk = 1'b0;
    logic rstn;
    always #5 memclk = ~memclk;

    sram_bank_responder_if if0 ();
    sram_bank_responder_if if2 ();

    sram_bank_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
        .memclk (memclk), .rstn (rstn), .mem_if (if0));
    sram_bank_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut2 (
        .memclk (memclk), .rstn (rstn), .mem_if (if2));

    typedef struct {
        int          s;      // 0 -> dut0, 1 -> dut2
        logic [31:0] addr;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [31:0] wd;
        bit          scr;    // scramble bus inputs while waiting
    } op_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic [3:0]  oe;
        logic        err;
        logic        rdy2;
    } res_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: only addresses 0..15 are used in range.
    logic [7:0]  mref [2][16][4];
    logic [31:0] rref [2];

    task automatic model_access(input op_t op, output res_t ex);
        bit coll;
        bit oor;
        coll = (op.rd != 4'd0) && (op.wr != 4'd0);
        oor  = (op.addr >= 32'h400);
        ex.cyc  = (op.s == 0) ? 1 : 3;
        ex.rdy2 = 1'b0;
        if (coll) begin
            ex.err = 1'b1;
            ex.oe  = 4'd0;
        end else if (oor) begin
            ex.err = 1'b1;
            ex.oe  = op.rd;
            for (int l = 0; l < 4; l++)
                if (op.rd[l]) rref[op.s][8*l +: 8] = 8'h00;
        end else begin
            ex.err = 1'b0;
            ex.oe  = op.rd;
            for (int l = 0; l < 4; l++) begin
                if (op.wr[l]) mref[op.s][op.addr[3:0]][l] = op.wd[8*l +: 8];
                if (op.rd[l]) rref[op.s][8*l +: 8] = mref[op.s][op.addr[3:0]][l];
            end
        end
        ex.rdata = rref[op.s];
    endtask

    task automatic drive(input int s, input logic [31:0] a, input logic [3:0] rd,
                         input logic [3:0] wr, input logic [31:0] wd);
        if (s == 0) begin
            if0.sram_addr = a; if0.sram_read = rd; if0.sram_write = wr; if0.sram_wdata = wd;
        end else begin
            if2.sram_addr = a; if2.sram_read = rd; if2.sram_write = wr; if2.sram_wdata = wd;
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? if0.sram_ready : if2.sram_ready;
    endfunction

    function automatic res_t snap(input int s);
        res_t r;
        r.cyc = 0; r.rdy2 = 1'b0;
        r.rdata = (s == 0) ? if0.sram_rdata    : if2.sram_rdata;
        r.oe    = (s == 0) ? if0.sram_rdata_oe : if2.sram_rdata_oe;
        r.err   = (s == 0) ? if0.sram_err      : if2.sram_err;
        return r;
    endfunction

    // Drive one request, hold it until ready, release, and record what the
    // DUT presented with the ready pulse and one cycle later.
    task automatic exec(input op_t op, output res_t ob, output res_t ex);
        int c_seen;
        model_access(op, ex);
        @(negedge memclk);
        drive(op.s, op.addr, op.rd, op.wr, op.wd);
        c_seen = 0;
        for (int c = 1; c <= 32; c++) begin
            @(posedge memclk); @(negedge memclk);
            if (rdy(op.s)) begin c_seen = c; break; end
            if (op.scr) drive(op.s, $urandom, 4'($urandom), 4'($urandom), $urandom);
        end
        ob = snap(op.s);
        ob.cyc = c_seen;
        drive(op.s, 32'd0, 4'd0, 4'd0, 32'd0);
        @(posedge memclk); @(negedge memclk);
        ob.rdy2 = rdy(op.s);
    endtask

    task automatic test_reset;
        res_t r;
        rstn = 1'b0;
        drive(0, 32'd0, 4'd0, 4'd0, 32'd0);
        drive(1, 32'd0, 4'd0, 4'd0, 32'd0);
        repeat (3) @(posedge memclk);
        @(negedge memclk);
        for (int s = 0; s < 2; s++) begin
            r = snap(s);
            n_checks += 4;
            if (rdy(s) !== 1'b0) begin n_fail++; $display("FAIL reset_ready dut%0d got %b want 0", s, rdy(s)); end
            if (r.err !== 1'b0) begin n_fail++; $display("FAIL reset_err dut%0d got %b want 0", s, r.err); end
            if (r.oe !== 4'd0) begin n_fail++; $display("FAIL reset_oe dut%0d got %b want 0000", s, r.oe); end
            if (r.rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata dut%0d got %h want 00000000", s, r.rdata); end
            rref[s] = 32'd0;
        end
        rstn = 1'b1;
    endtask

    task automatic test_word_lanes;
        op_t  tbl [5];
        res_t ob, ex;
        tbl[0] = '{0, 32'd5, 4'b0000, 4'b1111, 32'h11223344, 1'b0};
        tbl[1] = '{0, 32'd5, 4'b1111, 4'b0000, 32'h0,        1'b0};
        tbl[2] = '{0, 32'd5, 4'b0000, 4'b0100, 32'h00AA0000, 1'b0};
        tbl[3] = '{0, 32'd0, 4'b0000, 4'b1111, 32'h01020304, 1'b0};
        tbl[4] = '{0, 32'd5, 4'b0100, 4'b0000, 32'h0,        1'b0};
        foreach (tbl[i]) begin
            exec(tbl[i], ob, ex);
            n_checks += 5;
            if (ob.cyc !== ex.cyc) begin n_fail++; $display("FAIL lanes[%0d] latency got %0d want %0d", i, ob.cyc, ex.cyc); end
            if (ob.rdata !== ex.rdata) begin n_fail++; $display("FAIL lanes[%0d] rdata got %h want %h", i, ob.rdata, ex.rdata); end
            if (ob.oe !== ex.oe) begin n_fail++; $display("FAIL lanes[%0d] oe got %b want %b", i, ob.oe, ex.oe); end
            if (ob.err !== ex.err) begin n_fail++; $display("FAIL lanes[%0d] err got %b want %b", i, ob.err, ex.err); end
            if (ob.rdy2 !== 1'b0) begin n_fail++; $display("FAIL lanes[%0d] ready_width got %b want 0", i, ob.rdy2); end
        end
        // Word read after the lane-2 byte write: lanes 0x44/0x33/0xAA/0x11.
        exec('{0, 32'd5, 4'b1111, 4'b0000, 32'h0, 1'b0}, ob, ex);
        n_checks++;
        if (ob.rdata !== 32'h11AA3344) begin n_fail++; $display("FAIL lanes_byte_merge rdata got %h want 11aa3344", ob.rdata); end
    endtask

    task automatic test_wait_states;
        op_t  tbl [4];
        res_t ob, ex;
        tbl[0] = '{1, 32'd5, 4'b0000, 4'b1111, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{1, 32'd5, 4'b1111, 4'b0000, 32'h0,        1'b1};
        tbl[2] = '{1, 32'd9, 4'b0000, 4'b0011, 32'h0000C0DE, 1'b1};
        tbl[3] = '{1, 32'd5, 4'b0010, 4'b0000, 32'h0,        1'b1};
        foreach (tbl[i]) begin
            exec(tbl[i], ob, ex);
            n_checks += 5;
            if (ob.cyc !== ex.cyc) begin n_fail++; $display("FAIL wait[%0d] latency got %0d want %0d", i, ob.cyc, ex.cyc); end
            if (ob.rdata !== ex.rdata) begin n_fail++; $display("FAIL wait[%0d] rdata got %h want %h", i, ob.rdata, ex.rdata); end
            if (ob.oe !== ex.oe) begin n_fail++; $display("FAIL wait[%0d] oe got %b want %b", i, ob.oe, ex.oe); end
            if (ob.err !== ex.err) begin n_fail++; $display("FAIL wait[%0d] err got %b want %b", i, ob.err, ex.err); end
            if (ob.rdy2 !== 1'b0) begin n_fail++; $display("FAIL wait[%0d] ready_width got %b want 0", i, ob.rdy2); end
        end
    endtask

    task automatic test_collision;
        op_t  tbl [4];
        res_t ob, ex;
        tbl[0] = '{0, 32'd5, 4'b0001, 4'b0001, 32'h000000EE, 1'b0};
        tbl[1] = '{0, 32'd5, 4'b0001, 4'b0000, 32'h0,        1'b0};
        tbl[2] = '{1, 32'd5, 4'b1100, 4'b0011, 32'h55555555, 1'b0};
        tbl[3] = '{1, 32'd5, 4'b1111, 4'b0000, 32'h0,        1'b0};
        foreach (tbl[i]) begin
            exec(tbl[i], ob, ex);
            n_checks += 5;
            if (ob.cyc !== ex.cyc) begin n_fail++; $display("FAIL coll[%0d] latency got %0d want %0d", i, ob.cyc, ex.cyc); end
            if (ob.rdata !== ex.rdata) begin n_fail++; $display("FAIL coll[%0d] rdata got %h want %h", i, ob.rdata, ex.rdata); end
            if (ob.oe !== ex.oe) begin n_fail++; $display("FAIL coll[%0d] oe got %b want %b", i, ob.oe, ex.oe); end
            if (ob.err !== ex.err) begin n_fail++; $display("FAIL coll[%0d] err got %b want %b", i, ob.err, ex.err); end
            if (ob.rdy2 !== 1'b0) begin n_fail++; $display("FAIL coll[%0d] ready_width got %b want 0", i, ob.rdy2); end
        end
    endtask

    task automatic test_out_of_range;
        op_t  tbl [6];
        res_t ob, ex;
        tbl[0] = '{0, 32'h400,      4'b0000, 4'b1111, 32'hFFFFFFFF, 1'b0};
        tbl[1] = '{0, 32'h400,      4'b1111, 4'b0000, 32'h0,        1'b0};
        tbl[2] = '{0, 32'd0,        4'b1111, 4'b0000, 32'h0,        1'b0};
        tbl[3] = '{1, 32'h8000_0005,4'b0000, 4'b1111, 32'h0BADF00D, 1'b0};
        tbl[4] = '{1, 32'd5,        4'b1111, 4'b0000, 32'h0,        1'b0};
        tbl[5] = '{1, 32'h0000_0805,4'b0101, 4'b0000, 32'h0,        1'b1};
        foreach (tbl[i]) begin
            exec(tbl[i], ob, ex);
            n_checks += 5;
            if (ob.cyc !== ex.cyc) begin n_fail++; $display("FAIL oor[%0d] latency got %0d want %0d", i, ob.cyc, ex.cyc); end
            if (ob.rdata !== ex.rdata) begin n_fail++; $display("FAIL oor[%0d] rdata got %h want %h", i, ob.rdata, ex.rdata); end
            if (ob.oe !== ex.oe) begin n_fail++; $display("FAIL oor[%0d] oe got %b want %b", i, ob.oe, ex.oe); end
            if (ob.err !== ex.err) begin n_fail++; $display("FAIL oor[%0d] err got %b want %b", i, ob.err, ex.err); end
            if (ob.rdy2 !== 1'b0) begin n_fail++; $display("FAIL oor[%0d] ready_width got %b want 0", i, ob.rdy2); end
        end
    endtask

    // Write then read of the same word with no idle gap: the read strobes
    // replace the write strobes in the DONE cycle of the write.
    task automatic test_back_to_back;
        op_t  wop, rop;
        res_t ex_w, ex_r, r;
        int   c_seen;
        for (int s = 0; s < 2; s++) begin
            wop = '{s, 32'd3, 4'b0000, 4'b1111, $urandom, 1'b0};
            rop = '{s, 32'd3, 4'b1111, 4'b0000, 32'h0,   1'b0};
            model_access(wop, ex_w);
            model_access(rop, ex_r);
            @(negedge memclk);
            drive(s, wop.addr, wop.rd, wop.wr, wop.wd);
            c_seen = 0;
            for (int c = 1; c <= 32; c++) begin
                @(posedge memclk); @(negedge memclk);
                if (rdy(s)) begin c_seen = c; break; end
            end
            n_checks++;
            if (c_seen !== ex_w.cyc) begin n_fail++; $display("FAIL b2b_wr dut%0d latency got %0d want %0d", s, c_seen, ex_w.cyc); end
            drive(s, rop.addr, rop.rd, rop.wr, rop.wd);
            c_seen = 0;
            for (int c = 1; c <= 32; c++) begin
                @(posedge memclk); @(negedge memclk);
                if (rdy(s)) begin c_seen = c; break; end
            end
            r = snap(s);
            drive(s, 32'd0, 4'd0, 4'd0, 32'd0);
            n_checks += 3;
            if (c_seen !== ex_r.cyc + 1) begin n_fail++; $display("FAIL b2b_rd dut%0d spacing got %0d want %0d", s, c_seen, ex_r.cyc + 1); end
            if (r.rdata !== ex_r.rdata) begin n_fail++; $display("FAIL b2b_rd dut%0d rdata got %h want %h", s, r.rdata, ex_r.rdata); end
            if (r.err !== 1'b0) begin n_fail++; $display("FAIL b2b_rd dut%0d err got %b want 0", s, r.err); end
            @(posedge memclk);
        end
    endtask

    task automatic test_random;
        op_t  op;
        res_t ob, ex;
        int   kind;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16 + 40; a++) begin
                op.s = s;
                op.scr = (s == 1) && ($urandom_range(0, 1) == 1);
                op.wd = $urandom;
                if (a < 16) begin
                    op.addr = a; op.rd = 4'd0; op.wr = 4'b1111;
                end else begin
                    kind = $urandom_range(0, 9);
                    op.addr = (kind == 9) ? ($urandom | 32'h400) : 32'($urandom_range(0, 15));
                    op.rd = (kind >= 4) ? 4'($urandom_range(1, 15)) : 4'd0;
                    op.wr = (kind <= 3 || kind == 8) ? 4'($urandom_range(1, 15)) : 4'd0;
                end
                exec(op, ob, ex);
                n_checks += 5;
                if (ob.cyc !== ex.cyc) begin n_fail++; $display("FAIL rand dut%0d #%0d latency got %0d want %0d", s, a, ob.cyc, ex.cyc); end
                if (ob.rdata !== ex.rdata) begin n_fail++; $display("FAIL rand dut%0d #%0d rdata got %h want %h", s, a, ob.rdata, ex.rdata); end
                if (ob.oe !== ex.oe) begin n_fail++; $display("FAIL rand dut%0d #%0d oe got %b want %b", s, a, ob.oe, ex.oe); end
                if (ob.err !== ex.err) begin n_fail++; $display("FAIL rand dut%0d #%0d err got %b want %b", s, a, ob.err, ex.err); end
                if (ob.rdy2 !== 1'b0) begin n_fail++; $display("FAIL rand dut%0d #%0d ready_width got %b want 0", s, a, ob.rdy2); end
            end
        end
    endtask

    // Reset lands on the edge that would have committed the write.
    task automatic test_reset_in_wait;
        res_t r, ob, ex;
        logic saw_ready;
        @(negedge memclk);
        drive(1, 32'd7, 4'd0, 4'b1111, ~{mref[1][7][3], mref[1][7][2], mref[1][7][1], mref[1][7][0]});
        saw_ready = 1'b0;
        @(posedge memclk); @(negedge memclk);
        saw_ready |= rdy(1);
        @(posedge memclk); @(negedge memclk);
        saw_ready |= rdy(1);
        rstn = 1'b0;
        drive(1, 32'd0, 4'd0, 4'd0, 32'd0);
        @(posedge memclk); @(negedge memclk);
        saw_ready |= rdy(1);
        r = snap(1);
        n_checks += 4;
        if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait ready got %b want 0", saw_ready); end
        if (r.rdata !== 32'd0) begin n_fail++; $display("FAIL rst_wait rdata got %h want 00000000", r.rdata); end
        if (r.oe !== 4'd0) begin n_fail++; $display("FAIL rst_wait oe got %b want 0000", r.oe); end
        if (r.err !== 1'b0) begin n_fail++; $display("FAIL rst_wait err got %b want 0", r.err); end
        rref[0] = 32'd0;
        rref[1] = 32'd0;
        @(posedge memclk); @(negedge memclk);
        saw_ready = rdy(1);
        rstn = 1'b1;
        n_checks++;
        if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait ready_hold got %b want 0", saw_ready); end
        exec('{1, 32'd7, 4'b1111, 4'b0000, 32'h0, 1'b0}, ob, ex);
        n_checks += 3;
        if (ob.cyc !== ex.cyc) begin n_fail++; $display("FAIL rst_wait_read latency got %0d want %0d", ob.cyc, ex.cyc); end
        if (ob.rdata !== ex.rdata) begin n_fail++; $display("FAIL rst_wait_read rdata got %h want %h", ob.rdata, ex.rdata); end
        if (ob.err !== 1'b0) begin n_fail++; $display("FAIL rst_wait_read err got %b want 0", ob.err); end
        exec('{0, 32'd5, 4'b0000, 4'b0000, 32'h0, 1'b0}, ob, ex);
    endtask

    initial begin
        test_reset;
        test_word_lanes;
        test_wait_states;
        test_collision;
        test_out_of_range;
        test_back_to_back;
        test_random;
        test_reset_in_wait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
